// File: rtl/dw_conv_line_buf.sv
// dw_conv_line_buf: two-line buffer that turns a raster pixel stream into
// registered vertical 3-pixel columns per depthwise channel.
module dw_conv_line_buf #(
    parameter int CH_NUM     = 18,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sof,
    input  logic [CH_NUM*DATA_WIDTH-1:0]   data_in,
    input  logic                           valid_in,
    output logic [CH_NUM*3*DATA_WIDTH-1:0] col_out,
    output logic                           valid_out,
    output logic [$clog2(IMG_W)-1:0]       col_idx,
    output logic [$clog2(IMG_H)-1:0]       row_idx,
    output logic                           frame_done
);
    localparam int PW = CH_NUM*DATA_WIDTH;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [CW-1:0] col, c;
    logic [RW-1:0] row, r;
    logic last_col, last_row;
    logic [CH_NUM*3*DATA_WIDTH-1:0] col_nxt;
    // sof resynchronises the current beat itself, not just the next one
    assign c        = sof ? '0 : col;
    assign r        = sof ? '0 : row;
    assign last_col = c == CW'(IMG_W-1);
    assign last_row = r == RW'(IMG_H-1);
    always_comb begin
        col_nxt = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            col_nxt[(j*3+0)*DATA_WIDTH +: DATA_WIDTH] = lb1[c][j*DATA_WIDTH +: DATA_WIDTH];
            col_nxt[(j*3+1)*DATA_WIDTH +: DATA_WIDTH] = lb0[c][j*DATA_WIDTH +: DATA_WIDTH];
            col_nxt[(j*3+2)*DATA_WIDTH +: DATA_WIDTH] = data_in[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    // storage is left unreset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1[c] <= lb0[c];
            lb0[c] <= data_in;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col        <= '0;
            row        <= '0;
            col_out    <= '0;
            col_idx    <= '0;
            row_idx    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && r >= RW'(2);
            frame_done <= valid_in && last_col && last_row;
            if (valid_in) begin
                col_out <= col_nxt;
                col_idx <= c;
                row_idx <= r;
                col     <= last_col ? '0 : c + 1'b1;
                row     <= last_col ? (last_row ? '0 : r + 1'b1) : r;
            end
        end
    end
endmodule

// File: tb/tb_dw_conv_line_buf.sv
// tb_dw_conv_line_buf: scoreboard bench for a 4x4, 2-channel line buffer;
// channel 1 carries the inverse of channel 0 throughout.
module tb_dw_conv_line_buf;
    logic        clk = 0;
    logic        rstn = 0;
    logic        sof = 0;
    logic [15:0] data_in = '0;
    logic        valid_in = 0;
    logic [47:0] col_out;
    logic        valid_out;
    logic [1:0]  col_idx, row_idx;
    logic        frame_done;

    typedef struct {
        logic [47:0] col;
        logic [1:0]  ci;
        logic [1:0]  ri;
        logic        fd;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0, fd_cnt = 0;
    logic pv = 0;

    dw_conv_line_buf #(.CH_NUM(2), .DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rstn(rstn), .sof(sof), .data_in(data_in), .valid_in(valid_in),
        .col_out(col_out), .valid_out(valid_out), .col_idx(col_idx),
        .row_idx(row_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pixel value row*16+col; column slots are rows r-2, r-1, r
    function automatic logic [47:0] exp_col(input int r, input int c);
        logic [47:0] e;
        logic [7:0]  v;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            v = 8'((r - 2 + k)*16 + c);
            e[k*8 +: 8]     = v;
            e[(3+k)*8 +: 8] = ~v;
        end
        return e;
    endfunction

    task automatic beat(input int r, input int c, input logic s, input bit gaps);
        logic [7:0] v;
        v = 8'(r*16 + c);
        data_in  = {~v, v};
        sof      = s;
        valid_in = 1;
        if (r >= 2) q.push_back('{exp_col(r, c), 2'(c), 2'(r), r == 3 && c == 3});
        @(posedge clk); #1;
        valid_in = 0;
        sof      = 0;
        if (gaps) begin
            repeat ($urandom_range(5, 1)) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_col_out"}, 64'(col_out), 0);
        chk({tag, "_valid_out"}, 64'(valid_out), 0);
        chk({tag, "_col_idx"}, 64'(col_idx), 0);
        chk({tag, "_row_idx"}, 64'(row_idx), 0);
        chk({tag, "_frame_done"}, 64'(frame_done), 0);
    endtask

    task automatic chk_first(input string tag);
        @(negedge clk);
        chk({tag, "_col_idx"}, 64'(col_idx), 0);
        chk({tag, "_row_idx"}, 64'(row_idx), 0);
        chk({tag, "_valid_out"}, 64'(valid_out), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (q.size() == 0) chk("unexpected_valid", 64'(valid_out), 0);
                else begin
                    e = q.pop_front();
                    chk("col_out", 64'(col_out), 64'(e.col));
                    chk("col_idx", 64'(col_idx), 64'(e.ci));
                    chk("row_idx", 64'(row_idx), 64'(e.ri));
                    chk("frame_done", 64'(frame_done), 64'(e.fd));
                end
            end else if (frame_done) chk("frame_done_no_valid", 64'(frame_done), 0);
            if (!pv) chk("valid_after_idle", 64'(valid_out), 0);
            if (frame_done) fd_cnt++;
            pv = valid_in;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        @(negedge clk);
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        // frame A: continuous
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) beat(r, c, r == 0 && c == 0, 0);
        // frame B: first beat checked, rest with gaps and a stray idle sof
        beat(0, 0, 1, 0);
        chk_first("after_frame");
        for (int p = 1; p < 16; p++) begin
            beat(p/4, p%4, 0, 1);
            if (p == 6) begin
                sof = 1;
                @(posedge clk); #1;
                sof = 0;
            end
        end
        // frame C aborted by sof at row 2 col 2, frame D restarts there
        for (int p = 0; p < 10; p++) beat(p/4, p%4, p == 0, 0);
        beat(0, 0, 1, 0);
        chk_first("sof_resync");
        for (int p = 1; p < 16; p++) beat(p/4, p%4, 0, 1);
        // frame E cut by reset at row 3 col 1, frame F restarts without sof
        for (int p = 0; p < 13; p++) beat(p/4, p%4, p == 0, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 0;
        repeat (2) begin
            @(negedge clk);
            chk_zero("mid_reset");
            @(posedge clk);
        end
        #1 rstn = 1;
        beat(0, 0, 0, 0);
        chk_first("after_reset");
        for (int p = 1; p < 16; p++) beat(p/4, p%4, 0, 1);
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 0);
        chk("frame_done_count", 64'(fd_cnt), 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
